// File: rtl/cp0_pkg.sv
// Shared CP0 constants: {reg,sel} write addresses and Cause bit positions,
// used by both the CP0 register file and the interrupt/timer unit.
package cp0_pkg;

  localparam logic [7:0] CP0_COUNT   = 8'h48;  // {5'd9,  3'd0}
  localparam logic [7:0] CP0_COMPARE = 8'h58;  // {5'd11, 3'd0}
  localparam logic [7:0] CP0_CAUSE   = 8'h68;  // {5'd13, 3'd0}

  localparam int IP_LO = 8;
  localparam int TI    = 30;

endpackage

// File: rtl/cp0_int_sync.sv
// One hardware interrupt line: synchronizer chain, registered edge detect,
// and a level-following or edge-latched pending bit.
module cp0_int_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  input  logic clr,
  output logic pending
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_d_r;
  logic                   rise_r;
  logic                   pending_r;
  logic                   s_s;

  assign s_s = sync_r[SYNC_STAGES-1];

  // Synchronize, detect rising edge one flop later, update pending (set beats clear)
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_r    <= {SYNC_STAGES{1'b0}};
      s_d_r     <= 1'b0;
      rise_r    <= 1'b0;
      pending_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
      s_d_r  <= s_s;
      rise_r <= s_s & ~s_d_r;
      if (EDGE) begin
        pending_r <= rise_r | (pending_r & ~clr);
      end else begin
        pending_r <= s_s;
      end
    end
  end

  assign pending = pending_r;

endmodule

// File: rtl/cp0_int_timer.sv
// CP0 interrupt and timer unit: Count/Compare with prescaler, hardware and
// software interrupt pending vector, Cause.TI and registered interrupt request.
module cp0_int_timer
  import cp0_pkg::*;
#(
  parameter int                    HW_INT_NUM  = 6,
  parameter int                    SYNC_STAGES = 2,
  parameter int                    COUNT_DIV   = 2,
  parameter logic [HW_INT_NUM-1:0] EDGE_MASK   = {HW_INT_NUM{1'b0}},
  parameter int                    TIMER_LINE  = HW_INT_NUM - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  we,
  input  logic [4:0]            wr_addr,
  input  logic [2:0]            wr_sel,
  input  logic [31:0]           data_i,
  input  logic [HW_INT_NUM-1:0] hardware_int_in,
  input  logic [HW_INT_NUM-1:0] int_clr,
  input  logic [HW_INT_NUM+1:0] int_mask,
  input  logic                  int_ie,
  input  logic                  int_exl,
  input  logic                  int_erl,
  output logic [31:0]           count_o,
  output logic [31:0]           compare_o,
  output logic [HW_INT_NUM+1:0] ip_o,
  output logic                  ti_o,
  output logic                  int_req
);

  localparam int            PW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

  logic [PW-1:0]         presc_r;
  logic [31:0]           count_r;
  logic [31:0]           compare_r;
  logic                  ti_r;
  logic [1:0]            sw_r;
  logic                  int_req_r;
  logic [HW_INT_NUM-1:0] pending_s;
  logic [HW_INT_NUM+1:0] ip_s;
  logic [31:0]           count_inc_s;
  logic                  tick_s;
  logic                  wr_count_s;
  logic                  wr_compare_s;
  logic                  wr_cause_s;

  // Committed-write decode and timer tick
  always_comb begin
    wr_count_s   = 1'b0;
    wr_compare_s = 1'b0;
    wr_cause_s   = 1'b0;
    if (we && stall) begin
      case ({wr_addr, wr_sel})
        CP0_COUNT:   wr_count_s   = 1'b1;
        CP0_COMPARE: wr_compare_s = 1'b1;
        CP0_CAUSE:   wr_cause_s   = 1'b1;
        default:     wr_count_s   = 1'b0;
      endcase
    end else begin
      wr_count_s = 1'b0;
    end
    tick_s      = (presc_r == PRESC_MAX);
    count_inc_s = count_r + 32'd1;
  end

  // Count/Compare/TI: Count write beats tick; Compare write clear beats TI set
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_r   <= {PW{1'b0}};
      count_r   <= 32'd0;
      compare_r <= 32'd0;
      ti_r      <= 1'b0;
    end else begin
      if (wr_count_s) begin
        count_r <= data_i;
        presc_r <= {PW{1'b0}};
      end else if (tick_s) begin
        count_r <= count_inc_s;
        presc_r <= {PW{1'b0}};
      end else begin
        presc_r <= presc_r + PW'(1'b1);
      end
      if (wr_compare_s) begin
        compare_r <= data_i;
        ti_r      <= 1'b0;
      end else if (tick_s && !wr_count_s && (count_inc_s == compare_r)) begin
        ti_r <= 1'b1;
      end
    end
  end

  // Software interrupt bits from Cause writes
  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_r <= 2'b00;
    end else if (wr_cause_s) begin
      sw_r <= data_i[IP_LO+1:IP_LO];
    end
  end

  for (genvar i = 0; i < HW_INT_NUM; i++) begin : g_line
    cp0_int_sync #(
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE       (EDGE_MASK[i])
    ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_in(hardware_int_in[i]),
      .clr     (int_clr[i]),
      .pending (pending_s[i])
    );
  end

  // Pending vector with TI folded into the timer line
  always_comb begin
    ip_s                 = {pending_s, sw_r};
    ip_s[TIMER_LINE + 2] = pending_s[TIMER_LINE] | ti_r;
  end

  // Registered interrupt request
  always_ff @(posedge clk) begin
    if (!rst) begin
      int_req_r <= 1'b0;
    end else begin
      int_req_r <= (|(ip_s & int_mask)) & int_ie & ~int_exl & ~int_erl;
    end
  end

  assign count_o   = count_r;
  assign compare_o = compare_r;
  assign ip_o      = ip_s;
  assign ti_o      = ti_r;
  assign int_req   = int_req_r;

endmodule

// File: tb/tb_cp0_int_timer.sv
// Directed bench for cp0_int_timer: prescaler/wrap, TI set/clear, level and
// edge lines, software bits and gating, and mid-run reset.
module tb_cp0_int_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        we;
  logic [4:0]  wr_addr;
  logic [2:0]  wr_sel;
  logic [31:0] data_i;
  logic [5:0]  hardware_int_in;
  logic [5:0]  int_clr;
  logic [7:0]  int_mask;
  logic        int_ie, int_exl, int_erl;
  logic [31:0] count_o, compare_o;
  logic [7:0]  ip_o;
  logic        ti_o, int_req;

  int n_vec = 0;
  int n_err = 0;

  cp0_int_timer #(
    .HW_INT_NUM (6),
    .SYNC_STAGES(2),
    .COUNT_DIV  (2),
    .EDGE_MASK  (6'b000001),
    .TIMER_LINE (5)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .we(we), .wr_addr(wr_addr),
    .wr_sel(wr_sel), .data_i(data_i), .hardware_int_in(hardware_int_in),
    .int_clr(int_clr), .int_mask(int_mask), .int_ie(int_ie),
    .int_exl(int_exl), .int_erl(int_erl), .count_o(count_o),
    .compare_o(compare_o), .ip_o(ip_o), .ti_o(ti_o), .int_req(int_req)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cp0_write(input logic [7:0] addr, input logic [31:0] d);
    we      = 1'b1;
    stall   = 1'b1;
    wr_addr = addr[7:3];
    wr_sel  = addr[2:0];
    data_i  = d;
    step();
    we      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; we = 1'b0; wr_addr = 5'd0; wr_sel = 3'd0;
    data_i = 32'd0; hardware_int_in = 6'd0; int_clr = 6'd0; int_mask = 8'd0;
    int_ie = 1'b0; int_exl = 1'b0; int_erl = 1'b0;
    step(); step();
    n_vec++;
    if ({count_o, compare_o, ip_o, ti_o, int_req} !== 74'd0) begin
      n_err++;
      $display("FAIL reset_outputs got cnt=%h cmp=%h ip=%b ti=%b req=%b exp all 0",
               count_o, compare_o, ip_o, ti_o, int_req);
    end
    rst = 1'b1;
  endtask

  task automatic test_prescaler();
    int_mask = 8'h80; int_ie = 1'b1;
    cp0_write(8'h58, 32'h0000_0000);
    cp0_write(8'h48, 32'hFFFF_FFFE);
    step();
    n_vec++;
    if (count_o !== 32'hFFFF_FFFE) begin
      n_err++; $display("FAIL presc_hold got %h exp fffffffe", count_o);
    end
    step();
    n_vec++;
    if (count_o !== 32'hFFFF_FFFF || ti_o !== 1'b0) begin
      n_err++; $display("FAIL presc_tick1 got %h ti=%b exp ffffffff ti=0", count_o, ti_o);
    end
    step();
    n_vec++;
    if (count_o !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL presc_hold2 got %h exp ffffffff", count_o);
    end
    step();
    n_vec++;
    if (count_o !== 32'h0000_0000 || ti_o !== 1'b1 || ip_o !== 8'h80 || int_req !== 1'b0) begin
      n_err++;
      $display("FAIL presc_wrap_ti got cnt=%h ti=%b ip=%h req=%b exp 0 1 80 0",
               count_o, ti_o, ip_o, int_req);
    end
    step();
    n_vec++;
    if (int_req !== 1'b1) begin
      n_err++; $display("FAIL ti_int_req got %b exp 1", int_req);
    end
  endtask

  task automatic test_ti_clear();
    cp0_write(8'h58, 32'd5);
    n_vec++;
    if (ti_o !== 1'b0 || compare_o !== 32'd5) begin
      n_err++; $display("FAIL ti_clear got ti=%b cmp=%h exp 0 5", ti_o, compare_o);
    end
    cp0_write(8'h48, 32'd5);
    n_vec++;
    if (ti_o !== 1'b0 || count_o !== 32'd5) begin
      n_err++; $display("FAIL cnt_wr_eq got ti=%b cnt=%h exp 0 5", ti_o, count_o);
    end
    step(); step();
    n_vec++;
    if (ti_o !== 1'b0 || count_o !== 32'd6) begin
      n_err++; $display("FAIL tick_no_fire got ti=%b cnt=%h exp 0 6", ti_o, count_o);
    end
  endtask

  task automatic test_level_line();
    int_mask = 8'h10; int_ie = 1'b1; int_exl = 1'b0;
    hardware_int_in[2] = 1'b1;
    step(); step();
    n_vec++;
    if (ip_o[4] !== 1'b0) begin
      n_err++; $display("FAIL lvl_rise_early got %b exp 0", ip_o[4]);
    end
    step();
    n_vec++;
    if (ip_o[4] !== 1'b1 || int_req !== 1'b0) begin
      n_err++; $display("FAIL lvl_rise got ip4=%b req=%b exp 1 0", ip_o[4], int_req);
    end
    step();
    n_vec++;
    if (int_req !== 1'b1) begin
      n_err++; $display("FAIL lvl_req_rise got %b exp 1", int_req);
    end
    for (int k = 0; k < 6; k++) step();
    hardware_int_in[2] = 1'b0;
    step(); step();
    n_vec++;
    if (ip_o[4] !== 1'b1) begin
      n_err++; $display("FAIL lvl_fall_early got %b exp 1", ip_o[4]);
    end
    step();
    n_vec++;
    if (ip_o[4] !== 1'b0 || int_req !== 1'b1) begin
      n_err++; $display("FAIL lvl_fall got ip4=%b req=%b exp 0 1", ip_o[4], int_req);
    end
    step();
    n_vec++;
    if (int_req !== 1'b0) begin
      n_err++; $display("FAIL lvl_req_fall got %b exp 0", int_req);
    end
  endtask

  task automatic test_edge_line();
    int_mask = 8'h04;
    hardware_int_in[0] = 1'b1;
    step();
    hardware_int_in[0] = 1'b0;
    step(); step();
    n_vec++;
    if (ip_o[2] !== 1'b0) begin
      n_err++; $display("FAIL edge_early got %b exp 0", ip_o[2]);
    end
    step();
    n_vec++;
    if (ip_o[2] !== 1'b1) begin
      n_err++; $display("FAIL edge_latch got %b exp 1", ip_o[2]);
    end
    for (int k = 0; k < 5; k++) step();
    n_vec++;
    if (ip_o[2] !== 1'b1 || int_req !== 1'b1) begin
      n_err++; $display("FAIL edge_hold got ip2=%b req=%b exp 1 1", ip_o[2], int_req);
    end
    int_clr[0] = 1'b1;
    step();
    int_clr[0] = 1'b0;
    n_vec++;
    if (ip_o[2] !== 1'b0) begin
      n_err++; $display("FAIL edge_clr got %b exp 0", ip_o[2]);
    end
    hardware_int_in[0] = 1'b1;
    step();
    hardware_int_in[0] = 1'b0;
    step(); step();
    int_clr[0] = 1'b1;
    step();
    int_clr[0] = 1'b0;
    n_vec++;
    if (ip_o[2] !== 1'b1) begin
      n_err++; $display("FAIL edge_set_beats_clr got %b exp 1", ip_o[2]);
    end
    int_clr[0] = 1'b1;
    step();
    int_clr[0] = 1'b0;
    n_vec++;
    if (ip_o[2] !== 1'b0) begin
      n_err++; $display("FAIL edge_clr2 got %b exp 0", ip_o[2]);
    end
  endtask

  task automatic test_sw_gating();
    int_mask = 8'h01; int_ie = 1'b1; int_exl = 1'b0; int_erl = 1'b0;
    cp0_write(8'h68, 32'h0000_0100);
    n_vec++;
    if (ip_o[1:0] !== 2'b01) begin
      n_err++; $display("FAIL sw_bits got %b exp 01", ip_o[1:0]);
    end
    step();
    n_vec++;
    if (int_req !== 1'b1) begin
      n_err++; $display("FAIL sw_req got %b exp 1", int_req);
    end
    int_exl = 1'b1;
    step();
    n_vec++;
    if (int_req !== 1'b0) begin
      n_err++; $display("FAIL exl_gate got %b exp 0", int_req);
    end
    int_exl = 1'b0;
    step();
    int_erl = 1'b1;
    step();
    n_vec++;
    if (int_req !== 1'b0) begin
      n_err++; $display("FAIL erl_gate got %b exp 0", int_req);
    end
    int_erl = 1'b0;
    we = 1'b1; stall = 1'b0; wr_addr = 5'd13; wr_sel = 3'd0; data_i = 32'h0000_0200;
    step();
    we = 1'b0;
    n_vec++;
    if (ip_o[1:0] !== 2'b01 || int_req !== 1'b1) begin
      n_err++; $display("FAIL nostall_write got sw=%b req=%b exp 01 1", ip_o[1:0], int_req);
    end
  endtask

  task automatic test_mid_reset();
    hardware_int_in[0] = 1'b1;
    step();
    hardware_int_in[0] = 1'b0;
    step(); step(); step();
    cp0_write(8'h58, 32'd1);
    cp0_write(8'h48, 32'd0);
    step(); step();
    n_vec++;
    if (ti_o !== 1'b1 || count_o !== 32'd1 || ip_o !== 8'h85) begin
      n_err++; $display("FAIL pre_reset got ti=%b cnt=%h ip=%h exp 1 1 85", ti_o, count_o, ip_o);
    end
    rst = 1'b0;
    step();
    n_vec++;
    if ({count_o, compare_o, ip_o, ti_o, int_req} !== 74'd0) begin
      n_err++;
      $display("FAIL mid_reset got cnt=%h cmp=%h ip=%b ti=%b req=%b exp all 0",
               count_o, compare_o, ip_o, ti_o, int_req);
    end
    rst = 1'b1;
    step();
    n_vec++;
    if (count_o !== 32'd0) begin
      n_err++; $display("FAIL restart_hold got %h exp 0", count_o);
    end
    step();
    n_vec++;
    if (count_o !== 32'd1 || ip_o !== 8'h00) begin
      n_err++; $display("FAIL restart_tick got cnt=%h ip=%h exp 1 0", count_o, ip_o);
    end
  endtask

  initial begin
    test_reset();
    test_prescaler();
    test_ti_clear();
    test_level_line();
    test_edge_line();
    test_sw_gating();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cp0_int_timer.md
# cp0_int_timer

Parametrised interrupt and timer unit for the CP0 block. It owns the Count/Compare timer, a configurable clock prescaler, N hardware interrupt lines with per-line level or edge mode, and the two software interrupt bits. It produces the Cause.IP pending vector, Cause.TI, and a registered interrupt request for the exception unit. The unit sits beside the CP0 register file: the file forwards CP0 writes to it and reads Count, Compare, IP and TI back from it.

## Interface
- HW_INT_NUM, 6: number of hardware interrupt lines (1..6).
- SYNC_STAGES, 2: synchronizer flops per hardware line (>=2).
- COUNT_DIV, 2: Count increments once every COUNT_DIV cycles (>=1).
- EDGE_MASK, 0: HW_INT_NUM bits; bit i=1 makes line i edge-latched, 0 makes it level.
- TIMER_LINE, HW_INT_NUM-1: hardware line index that TI is ORed into.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-low reset.
- stall  in  1  commit strobe; a write takes effect only when we & stall.
- we  in  1  CP0 write enable.
- wr_addr  in  5  CP0 register number.
- wr_sel  in  3  CP0 select.
- data_i  in  32  write data.
- hardware_int_in  in  HW_INT_NUM  asynchronous external interrupt lines.
- int_clr  in  HW_INT_NUM  one-cycle clear of edge-latched pending bits; ignored for level lines.
- int_mask  in  HW_INT_NUM+2  Status.IM, where bits 1:0 are the software bits.
- int_ie, int_exl, int_erl  in  1 each  Status.IE, Status.EXL, Status.ERL.
- count_o  out  32  Count register.
- compare_o  out  32  Compare register.
- ip_o  out  HW_INT_NUM+2  pending vector, where bits 1:0 are software and bit i+2 is line i.
- ti_o  out  1  timer interrupt flag (Cause.TI).
- int_req  out  1  registered interrupt request.

## Operation
- All outputs reset to 0. Count, Compare, the prescaler, TI, the software bits, every synchronizer flop and every pending latch also reset to 0.
- Writes are decoded on {wr_addr,wr_sel} as follows:
  - Count is {9,0}.
  - Compare is {11,0}.
  - Cause is {13,0}; only data_i[9:8] is stored, into the software bits.
  - Any other address is ignored.
- The prescaler counts 0..COUNT_DIV-1. A tick occurs when the prescaler equals COUNT_DIV-1; the prescaler then wraps to 0.
- On a tick, Count becomes Count+1 modulo 2^32, so 0xFFFFFFFF wraps to 0.
- A Count write loads data_i and resets the prescaler to 0. It beats a tick in the same cycle.
- Setting TI: when a tick occurs and Count+1 == Compare, TI is set in the same edge that updates Count.
  - Equality produced by a Count write does not set TI.
  - Equality at reset does not set TI.
- Clearing TI: a Compare write loads data_i and clears TI. If a TI set and a Compare write land in the same cycle, the clear wins.
- Each hardware line passes through SYNC_STAGES flops. The synchronized value is s[i].
- Level line: pending[i] = s[i] each cycle.
- Edge line: pending[i] is set on a 0→1 transition of s[i] and cleared by int_clr[i]. If set and clear coincide, set wins.
- ip_o[i+2] = pending[i], except ip_o[TIMER_LINE+2] = pending[TIMER_LINE] | TI.
- ip_o[1:0] = the software bits.
- int_req is registered from |(ip_o & int_mask) & int_ie & ~int_exl & ~int_erl.

## Timing
- Hardware line to ip_o:
  - Level line: SYNC_STAGES+1 cycles.
  - Edge line: SYNC_STAGES+2 cycles, because the edge detect adds one flop.
- ip_o to int_req: 1 cycle.
- Writes are visible on count_o, compare_o, ip_o[1:0] and ti_o the cycle after the committed write edge.
- With Count written to X at edge t, Count reads X+1 after edge t+COUNT_DIV.
- When TI is set, ti_o and ip_o reflect it on the same edge that Count reaches Compare. int_req follows 1 cycle later.
- A reset asserted mid-operation clears all state at the next edge. Pending edges and in-flight synchronizer values are lost.

## Structure
- The shared package cp0_pkg holds:
  - the CP0 address constants CP0_COUNT, CP0_COMPARE and CP0_CAUSE as {reg,sel} 8-bit values;
  - the Cause bit-position constants (IP_LO=8, TI=30).
  - The CP0 register file uses the same constants.
- Sub-module cp0_int_sync: one hardware line's synchronizer chain, edge detector and edge/level pending latch, parametrised by SYNC_STAGES and EDGE. It is instantiated HW_INT_NUM times in a generate loop.

## Test plan
- Prescaler: with COUNT_DIV=2, write Count=0xFFFFFFFE, Compare=0 (stall=1). Required: count_o reads 0xFFFFFFFF then 0x00000000 at 2-cycle spacing, and ti_o=1 on the wrap edge.
- TI clear: after TI=1, write Compare=5. Required: ti_o=0 next cycle. Then write Count=5. Required: ti_o stays 0. Count then ticks 5→6 with no fire.
- Level line: with EDGE_MASK=0 and SYNC_STAGES=2, pulse hardware_int_in[2] high for 10 cycles with int_mask[4]=1, int_ie=1, int_exl=0. Required: ip_o[4] rises 3 cycles after the input and int_req 1 cycle after that. Both fall on the same delays after release.
- Edge line: with EDGE_MASK[0]=1, apply a 1-cycle pulse on line 0 (held for the synchronizer). Required: ip_o[2] latches and stays 1 until int_clr[0]. int_clr[0] coincident with a new rising edge leaves ip_o[2]=1.
- Software bits and gating: write Cause with data_i[9:8]=2'b01 and int_mask[0]=1. Required: ip_o[0]=1 and int_req=1. Raising int_exl or int_erl drops int_req within 1 cycle. A write with stall=0 has no effect.
- Reset: assert rst=0 mid-count with TI=1 and pending set. Required: every output is 0 at the next edge, and Count restarts from 0 after release.
